// File: rtl/permute_slices_pkg.sv
// permute_slices_pkg: shared sizes, FSM states and slice type for the encoder datapath stages
package permute_slices_pkg;
  localparam int SLICES = 64;
  localparam int AW = 6;
  localparam int W = 25;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
  typedef logic [0:W-1] slice_t;
endpackage

// File: rtl/permute_slices_pi_slice.sv
// pi_slice: combinational pi lane permutation of one 5x5 slice, bit i is (x = i mod 5, y = i div 5)
module pi_slice
  import permute_slices_pkg::*;
(
  input  logic [0:W-1] din,
  output logic [0:W-1] dout
);
  for (genvar y = 0; y < 5; y++) begin : g_y
    for (genvar x = 0; x < 5; x++) begin : g_x
      assign dout[5*y+x] = din[5*x+((x+3*y)%5)];
    end
  end
endmodule

// File: rtl/permute_slices.sv
// permute_slices: walks the slice memory once per start, writing pi(slice) to the next stage memory
module permute_slices
  import permute_slices_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start_per,
  output logic          ready_per,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [0:W-1]  rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [0:W-1]  wr_data
);
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic valid_q, valid_d;
  assign rd_en = state_q == RUN;
  assign rd_addr = cnt_q;
  assign ready_per = state_q == DONE;
  assign wr_en = valid_q;
  assign wr_addr = addr_q;
  pi_slice u_pi (.din(rd_data), .dout(wr_data));
  // next state: one read per RUN cycle, one flush cycle for the last write, then a done pulse
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start_per) begin
        state_d = RUN;
        cnt_d = '0;
      end
      RUN: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(SLICES - 1)) state_d = FLUSH;
      end
      FLUSH: state_d = DONE;
      default: state_d = IDLE;
    endcase
    valid_d = rd_en;
    addr_d = rd_addr;
  end
  // state, counter and write-pipeline registers; the write lags its read by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      valid_q <= 1'b0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      addr_q <= addr_d;
    end
  end
endmodule
